// File: rtl/dot_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_sched_pkg
// Description : Shared coordinate widths, scheduler state encoding and the
//               buffered dot-update entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_sched_pkg;

    localparam int X_WIDTH          = 10;
    localparam int Y_WIDTH          = 9;
    localparam int DEFAULT_ID_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_X = 2'd1,
        DRIVE_Y = 2'd2,
        DONE    = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [DEFAULT_ID_WIDTH-1:0] id;
        logic [X_WIDTH-1:0]          x;
        logic [Y_WIDTH-1:0]          y;
    } dot_entry_t;

endpackage : dot_sched_pkg
`default_nettype wire

// File: rtl/dot_update_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dot_update_fifo
// Description : Synchronous show-ahead FIFO. The head entry and the entry
//               behind it are both visible combinationally so the consumer
//               can chain to the next entry on the same edge it pops.
// Ports       : clk, rst (async, active-high)
//               push/wdata     - write side, ignored when full
//               pop            - read side, ignored when empty
//               head_data      - oldest entry
//               next_data      - second-oldest entry (valid when count >= 2)
//               count/full/empty - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module dot_update_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 25
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int                c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]    count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == c_full);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[rd_ptr_q + 1'b1];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule : dot_update_fifo
`default_nettype wire

// File: rtl/dot_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dot_update_scheduler
// Description : Buffers (id, x, y) dot updates and replays them into the VGA
//               dot write port only after a frame ends, as an X write then a
//               Y write per entry, each held HOLD_CYCLES clocks.
// Ports       : clk, reset (async, active-high), screenEnd (frame-end strobe)
//               push_valid/push_ready/push_id/push_x/push_y - update input
//               dotWren/is_Yloc/dotID/dotLoc - VGA dot write port
//               frame_done - one-clk pulse when a drain completes
//               fifo_count - occupancy, overflow - sticky dropped-push flag
// Revision    : 1.0 - initial release
// ============================================================================
module dot_update_scheduler
    import dot_sched_pkg::*;
#(
    parameter int FIFO_DEPTH    = 64,
    parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
    parameter int HOLD_CYCLES   = 4,
    parameter int MAX_PER_FRAME = 45
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          screenEnd,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [ID_WIDTH-1:0]           push_id,
    input  logic [X_WIDTH-1:0]            push_x,
    input  logic [Y_WIDTH-1:0]            push_y,
    output logic                          dotWren,
    output logic                          is_Yloc,
    output logic [31:0]                   dotID,
    output logic [31:0]                   dotLoc,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int c_entry_w = ID_WIDTH + X_WIDTH + Y_WIDTH;
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_hold_w  = $clog2(HOLD_CYCLES + 1);
    localparam int c_drain_w = $clog2(MAX_PER_FRAME + 1);

    localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_drain_w-1:0] c_max_drain = c_drain_w'(MAX_PER_FRAME);
    localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);

    sched_state_t            state_q, state_d;
    logic [c_hold_w-1:0]     hold_q, hold_d;
    logic [c_drain_w-1:0]    drained_q, drained_d;
    logic                    se_q, se_d;
    logic                    wren_q, wren_d;
    logic                    is_y_q, is_y_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [X_WIDTH-1:0]      loc_q, loc_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overflow_q, overflow_d;

    logic                    w_rise;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [c_cnt_w-1:0]      w_count;
    logic [c_entry_w-1:0]    w_head;
    logic [c_entry_w-1:0]    w_next;
    logic [c_entry_w-1:0]    w_src;
    logic [ID_WIDTH-1:0]     w_src_id;
    logic [X_WIDTH-1:0]      w_src_x;
    logic [Y_WIDTH-1:0]      w_src_y;
    logic [c_drain_w-1:0]    w_drained_inc;

    dot_update_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (w_push),
        .wdata     ({push_id, push_x, push_y}),
        .pop       (w_pop),
        .head_data (w_head),
        .next_data (w_next),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_rise        = screenEnd & ~se_q;
    assign w_push        = push_valid & ~w_full;
    assign w_drained_inc = drained_q + 1'b1;

    // While finishing a Y write the head is about to be popped, so the entry
    // to load is the one behind it; otherwise the head itself is the source.
    assign w_src    = (state_q == DRIVE_Y) ? w_next : w_head;
    assign w_src_id = w_src[c_entry_w-1 -: ID_WIDTH];
    assign w_src_x  = w_src[Y_WIDTH +: X_WIDTH];
    assign w_src_y  = w_src[Y_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        drained_d    = drained_q;
        se_d         = screenEnd;
        wren_d       = wren_q;
        is_y_d       = is_y_q;
        id_d         = id_q;
        loc_d        = loc_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (push_valid & w_full);
        w_pop        = 1'b0;

        case (state_q)
            IDLE: begin
                wren_d = 1'b0;
                if (w_rise) begin
                    if (!w_empty) begin
                        state_d   = DRIVE_X;
                        wren_d    = 1'b1;
                        is_y_d    = 1'b0;
                        id_d      = w_src_id;
                        loc_d     = w_src_x;
                        hold_d    = '0;
                        drained_d = '0;
                    end else begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            DRIVE_X: begin
                if (hold_q == c_hold_last) begin
                    state_d = DRIVE_Y;
                    is_y_d  = 1'b1;
                    loc_d   = {{(X_WIDTH-Y_WIDTH){1'b0}}, w_src_y};
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DRIVE_Y: begin
                if (hold_q == c_hold_last) begin
                    w_pop     = 1'b1;
                    drained_d = w_drained_inc;
                    // Chain straight into the next X write so dotWren never gaps.
                    if ((w_count > c_cnt_one) && (w_drained_inc < c_max_drain)) begin
                        state_d = DRIVE_X;
                        is_y_d  = 1'b0;
                        id_d    = w_src_id;
                        loc_d   = w_src_x;
                        hold_d  = '0;
                    end else begin
                        state_d      = DONE;
                        wren_d       = 1'b0;
                        is_y_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                wren_d  = 1'b0;
                is_y_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                wren_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            drained_q    <= '0;
            se_q         <= 1'b0;
            wren_q       <= 1'b0;
            is_y_q       <= 1'b0;
            id_q         <= '0;
            loc_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            drained_q    <= drained_d;
            se_q         <= se_d;
            wren_q       <= wren_d;
            is_y_q       <= is_y_d;
            id_q         <= id_d;
            loc_q        <= loc_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign push_ready = ~w_full;
    assign dotWren    = wren_q;
    assign is_Yloc    = is_y_q;
    assign dotID      = {{(32-ID_WIDTH){1'b0}}, id_q};
    assign dotLoc     = {{(32-X_WIDTH){1'b0}}, loc_q};
    assign frame_done = frame_done_q;
    assign fifo_count = w_count;
    assign overflow   = overflow_q;

endmodule : dot_update_scheduler
`default_nettype wire

// File: doc/dot_update_scheduler.md
Name: dot_update_scheduler

Overview:
- Buffers dot position updates (id, x, y) pushed by the processor.
- Replays them into the VGA controller's dot write port (dotWren/is_Yloc/dotID/dotLoc), but only after a frame ends (screenEnd rising edge). Dots therefore never move mid-frame.
- Each buffered entry becomes an X write followed by a Y write. Each write is held long enough to be sampled by the 25 MHz pixel-domain registers.
- Emits frame_done to tell the processor that the next batch may be computed.

Parameters:
- FIFO_DEPTH, 64, number of buffered (id, x, y) entries; power of two.
- ID_WIDTH, 6, dot index width (covers NUM_DOTS = 45).
- HOLD_CYCLES, 4, clk cycles each X or Y write is held; must be ≥ clk/clk25 ratio.
- MAX_PER_FRAME, 45, maximum entries drained per screenEnd event.

Ports:
- clk  input  1  100 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- screenEnd  input  1  frame-end strobe from the VGA timing generator.
- push_valid  input  1  processor offers an entry.
- push_ready  output  1  entry accepted on an edge where push_valid & push_ready.
- push_id  input  ID_WIDTH  dot index.
- push_x  input  10  x coordinate, 0..639.
- push_y  input  9  y coordinate, 0..479.
- dotWren  output  1  write strobe to the VGA controller.
- is_Yloc  output  1  0 = x write, 1 = y write.
- dotID  output  32  zero-extended dot index.
- dotLoc  output  32  zero-extended coordinate.
- frame_done  output  1  one-clk pulse when a frame's drain completes.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when push_valid & ~push_ready.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - dotWren=0, is_Yloc=0, dotID=0, dotLoc=0.
  - frame_done=0, overflow=0, fifo_count=0, push_ready=1.
  - FIFO emptied, state=IDLE, se_q=0.
- Reset asserted mid-drain: dotWren drops immediately (asynchronous); the partial entry is discarded.
- Edge detect:
  - se_q registers screenEnd each clk.
  - rise = screenEnd & ~se_q.
  - screenEnd is held for about 4 clk cycles; only the first cycle counts.
- push_ready = (fifo_count < FIFO_DEPTH). It is registered-count based and does not see a same-cycle pop.
- A push and a pop on the same edge are legal; fifo_count is then unchanged.
- FIFO is show-ahead: the head entry is visible without a pop.
- FSM states: IDLE, DRIVE_X, DRIVE_Y, DONE.
  - IDLE: dotWren=0.
    - On rise with fifo_count>0: capture head into the output regs on the same edge and go to DRIVE_X. Outputs become dotWren=1, is_Yloc=0, dotID={0,id}, dotLoc={0,x}. Reset hold counter and set drained=0.
    - On rise with FIFO empty: go to DONE.
  - DRIVE_X: hold outputs for exactly HOLD_CYCLES clk cycles. Then go to DRIVE_Y: is_Yloc=1, dotLoc={0,y}, dotID unchanged, dotWren stays 1.
  - DRIVE_Y: hold for HOLD_CYCLES. On the final cycle, pop the FIFO and increment drained.
    - If (fifo_count after pop)>0 and drained<MAX_PER_FRAME: load the next head directly into DRIVE_X. dotWren stays high and there is no gap.
    - Otherwise go to DONE.
  - DONE: dotWren=0, is_Yloc=0, frame_done=1 for one cycle, then IDLE.
- Latency:
  - First write is visible the edge after the rise is detected.
  - An entry occupies 2×HOLD_CYCLES clk.
  - 45 entries take 360 clk, well inside vertical blanking.
- A rise seen while not in IDLE is ignored; no restart or re-arm.
- Entries beyond MAX_PER_FRAME stay queued for the next frame, in order.
- Pushes are accepted in any state, including during a drain.
- Duplicate ids are replayed in order; the last one wins at the display.
- push_x ≥ 640 and push_y ≥ 480 are passed through unchecked.

Decomposition:
- Shared package dot_sched_pkg holds:
  - X_WIDTH=10, Y_WIDTH=9, DEFAULT_ID_WIDTH=6.
  - The state enum {IDLE, DRIVE_X, DRIVE_Y, DONE}.
  - The packed entry struct {id, x, y}.
- One sub-module: dot_update_fifo. It is a synchronous show-ahead FIFO on clk with async reset, push/pop, count, full and empty.
- The FSM, hold counter, drain counter and edge detect live in the top.

Test Plan:
- Push (id=3, x=100, y=200), no screenEnd for 1000 cycles -> dotWren stays 0 and fifo_count=1. Then a 4-cycle screenEnd pulse gives:
  - dotWren=1, is_Yloc=0, dotID=3, dotLoc=100 for 4 cycles;
  - then is_Yloc=1, dotLoc=200 for 4 cycles;
  - then frame_done pulses once and fifo_count=0.
- Push 50 entries (id=i, x=i, y=i), then a screenEnd pulse -> exactly 45 entries are drained back-to-back (360 cycles of dotWren=1), frame_done fires and fifo_count=5. The next screenEnd drains ids 45..49.
- screenEnd with an empty FIFO -> frame_done pulses one cycle after the rise, dotWren never asserts.
- Push continuously until full (64) with push_valid held -> push_ready=0, overflow=1 (sticky after push_valid drops), fifo_count stays 64. A push that coincides with a pop on a non-full FIFO leaves the count unchanged.
- A second screenEnd pulse arriving during a drain -> ignored; the drain order and count are unaffected and there is a single frame_done.
- Assert reset in the 3rd cycle of DRIVE_Y -> dotWren=0 in the same cycle, fifo_count=0, overflow=0. The first screenEnd after reset produces only frame_done.
